// File: rtl/ram_wstrb_pipe.sv
// rtl/ram_wstrb_pipe.sv - byte-strobed single-port RAM with request handshake, read pipe and clear sweep
module ram_wstrb_pipe #(
    parameter int                BITS           = 64,
    parameter int                ADDRESS_BITS   = 14,
    parameter int                READ_LATENCY   = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [BITS-1:0]   CLEAR_VALUE    = '0
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_BITS-1:0] addr,
    input  logic [BITS-1:0]         data_in,
    input  logic                    WRb,
    input  logic [BITS/8-1:0]       wstrb,
    output logic [BITS-1:0]         data_out,
    output logic                    rd_valid,
    output logic                    busy
);
    localparam int LANES = BITS / 8;
    localparam int DEPTH = 1 << ADDRESS_BITS;
    localparam logic [ADDRESS_BITS:0] CNT_LAST = (ADDRESS_BITS+1)'(DEPTH - 1);
    localparam logic [ADDRESS_BITS:0] CNT_ONE  = (ADDRESS_BITS+1)'(1);

    generate
        if ((BITS % 8) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_param_err
            $error("ram_wstrb_pipe: BITS must be a multiple of 8 and READ_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                 r_state;
    logic [ADDRESS_BITS:0]  r_clr_cnt;
    logic                   r_req_ready;
    logic                   r_busy;
    logic [BITS-1:0]        r_mem [DEPTH];
    logic [BITS-1:0]        r_s1_data;
    logic                   r_s1_valid;

    logic w_accept;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_clr_we;

    // r_req_ready is only ever high in RUN, so it also gates acceptance
    assign w_accept = req_valid && r_req_ready;
    assign w_rd_acc = w_accept && WRb;
    assign w_wr_acc = w_accept && !WRb;
    assign w_clr_we = (r_state == ST_CLEAR) && RSTb;

    assign req_ready = r_req_ready;
    assign busy      = r_busy;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            if (CLEAR_ON_RESET != 0) r_state <= ST_CLEAR;
            else                     r_state <= ST_RUN;
            r_clr_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= (CLEAR_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + CNT_ONE;
                    if (r_clr_cnt == CNT_LAST) begin
                        r_state     <= ST_RUN;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Array carries no reset so it can map onto block RAM
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt[ADDRESS_BITS-1:0]] <= CLEAR_VALUE;
        end else if (w_wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb[i]) r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) r_s1_data <= r_mem[addr];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [BITS-1:0] r_s2_data;
            logic            r_s2_valid;

            always_ff @(posedge CLK or negedge RSTb) begin
                if (!RSTb) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) r_s2_data <= r_s1_data;
                end
            end

            assign data_out = r_s2_data;
            assign rd_valid = r_s2_valid;
        end else begin : g_lat1
            assign data_out = r_s1_data;
            assign rd_valid = r_s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_wstrb_pipe.sv
// tb/tb_ram_wstrb_pipe.sv - randomized bench for ram_wstrb_pipe against a word/byte-mask memory model
module tb_ram_wstrb_pipe;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int ND    = 3;
    localparam logic [63:0] CV = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam int LAT [ND] = '{1, 2, 1};
    localparam int CLR [ND] = '{1, 1, 0};

    logic          CLK = 1'b0;
    logic          RSTb = 1'b0;
    logic          req_valid = 1'b0;
    logic          WRb = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [63:0]   data_in = '0;
    logic [7:0]    wstrb = '0;

    logic [63:0] dout [ND];
    logic        rv   [ND];
    logic        rdy  [ND];
    logic        bsy  [ND];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ram_wstrb_pipe #(.BITS(64), .ADDRESS_BITS(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u_lat1 (
        .CLK(CLK), .RSTb(RSTb), .req_valid(req_valid), .req_ready(rdy[0]), .addr(addr),
        .data_in(data_in), .WRb(WRb), .wstrb(wstrb), .data_out(dout[0]), .rd_valid(rv[0]), .busy(bsy[0]));

    ram_wstrb_pipe #(.BITS(64), .ADDRESS_BITS(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u_lat2 (
        .CLK(CLK), .RSTb(RSTb), .req_valid(req_valid), .req_ready(rdy[1]), .addr(addr),
        .data_in(data_in), .WRb(WRb), .wstrb(wstrb), .data_out(dout[1]), .rd_valid(rv[1]), .busy(bsy[1]));

    ram_wstrb_pipe #(.BITS(64), .ADDRESS_BITS(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(0), .CLEAR_VALUE(CV)) u_nocl (
        .CLK(CLK), .RSTb(RSTb), .req_valid(req_valid), .req_ready(rdy[2]), .addr(addr),
        .data_in(data_in), .WRb(WRb), .wstrb(wstrb), .data_out(dout[2]), .rd_valid(rv[2]), .busy(bsy[2]));

    // Reference: memory words plus a mask of bytes whose content is known
    typedef struct {
        int          d;
        int          due;
        logic [63:0] data;
        logic [63:0] mask;
    } rd_t;

    logic [63:0] mm [ND][DEPTH];
    logic [63:0] mk [ND][DEPTH];
    int          edges [ND];
    logic        e_rdy [ND];
    logic        e_bsy [ND];
    logic        e_rv  [ND];
    logic [63:0] e_dout  [ND];
    logic [63:0] e_dmask [ND];
    rd_t         pend [$];
    int          cyc = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] strb_mask(input logic [7:0] s);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            edges[d]   = 0;
            e_rdy[d]   = 1'b0;
            e_bsy[d]   = (CLR[d] != 0);
            e_rv[d]    = 1'b0;
            e_dout[d]  = '0;
            e_dmask[d] = '1;
            if (CLR[d] != 0) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mm[d][a] = CV;
                    mk[d][a] = '1;
                end
            end
        end
        pend.delete();
    endtask

    task automatic model_edge();
        rd_t         r;
        logic [63:0] m;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (e_rdy[d] && req_valid) begin
                if (WRb) begin
                    r.d    = d;
                    r.due  = cyc + LAT[d] - 1;
                    r.data = mm[d][addr];
                    r.mask = mk[d][addr];
                    pend.push_back(r);
                end else begin
                    m = strb_mask(wstrb);
                    mm[d][addr] = (mm[d][addr] & ~m) | (data_in & m);
                    mk[d][addr] = mk[d][addr] | m;
                end
            end
            edges[d]++;
            e_rdy[d] = (CLR[d] != 0) ? (edges[d] >= DEPTH) : (edges[d] >= 1);
            e_bsy[d] = (CLR[d] != 0) && (edges[d] < DEPTH);
            e_rv[d]  = 1'b0;
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due == cyc) begin
                e_rv[pend[i].d]    = 1'b1;
                e_dout[pend[i].d]  = pend[i].data;
                e_dmask[pend[i].d] = pend[i].mask;
                pend.delete(i);
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("req_ready[%0d]", d), 64'(rdy[d]), 64'(e_rdy[d]));
            check($sformatf("busy[%0d]", d),      64'(bsy[d]), 64'(e_bsy[d]));
            check($sformatf("rd_valid[%0d]", d),  64'(rv[d]),  64'(e_rv[d]));
            check($sformatf("data_out[%0d]", d),  dout[d] & e_dmask[d], e_dout[d] & e_dmask[d]);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        if (RSTb) model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
    endtask

    task automatic drive_req(input logic wrb, input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s);
        req_valid = 1'b1;
        WRb       = wrb;
        addr      = a;
        data_in   = d;
        wstrb     = s;
    endtask

    task automatic drive_random();
        req_valid = ($urandom_range(0, 3) != 0);
        WRb       = 1'($urandom_range(0, 1));
        addr      = 4'($urandom);
        data_in   = {$urandom(), $urandom()};
        wstrb     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    endtask

    initial begin
        logic [63:0] t4_data;
        for (int a = 0; a < DEPTH; a++) begin
            mm[2][a] = '0;
            mk[2][a] = '0;
        end
        RSTb = 1'b0;
        model_reset();
        repeat (3) step();
        RSTb = 1'b1;

        // Sweep runs while requests are idle; u_nocl is ready after one edge
        step();
        check("nocl_ready_first_cycle", 64'(rdy[2]), 64'd1);
        repeat (19) step();

        for (int a = 0; a < DEPTH; a++) begin
            drive_req(1'b1, 4'(a), '0, '0);
            step();
        end
        drive_idle();
        repeat (3) step();

        // Partial-strobe merge on address 3
        drive_req(1'b0, 4'd3, 64'h1122_3344_5566_7788, 8'hFF);
        step();
        drive_req(1'b0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h05);
        step();
        drive_req(1'b1, 4'd3, '0, '0);
        step();
        check("strobe_merge_lat1", dout[0], 64'h1122_3344_55FF_77FF);
        check("strobe_merge_nocl", dout[2], 64'h1122_3344_55FF_77FF);
        drive_idle();
        step();
        check("strobe_merge_lat2", dout[1], 64'h1122_3344_55FF_77FF);
        repeat (2) step();

        // Read immediately after write to the same address
        t4_data = {$urandom(), $urandom()};
        drive_req(1'b0, 4'd5, t4_data, 8'hFF);
        step();
        drive_req(1'b1, 4'd5, '0, '0);
        step();
        check("raw_same_addr_lat1", dout[0], t4_data);
        drive_idle();
        step();
        check("raw_same_addr_lat2", dout[1], t4_data);

        for (int a = 1; a <= 3; a++) begin
            drive_req(1'b1, 4'(a), '0, '0);
            step();
        end
        drive_idle();
        repeat (3) step();

        repeat (300) begin
            drive_random();
            step();
        end
        drive_idle();
        repeat (3) step();

        // Reset partway through a sweep, with traffic running throughout
        RSTb = 1'b0;
        model_reset();
        repeat (2) step();
        RSTb = 1'b1;
        repeat (9) begin
            drive_random();
            step();
        end
        RSTb = 1'b0;
        model_reset();
        drive_idle();
        repeat (2) step();
        RSTb = 1'b1;
        repeat (120) begin
            drive_random();
            step();
        end

        for (int a = 0; a < DEPTH; a++) begin
            drive_req(1'b1, 4'(a), '0, '0);
            step();
        end
        drive_idle();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
